mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 89 ++++++++
 tb/tb_mem_port_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester single-port memory arbiter with bounded bursts
// and a one-cycle registered read return routed back to the granted requester.
module mem_port_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        iwClk,
    input  logic        iwRst,
    input  logic        iwReq0,
    input  logic        iwWe0,
    input  logic [31:0] iwAddr0,
    input  logic [31:0] iwWData0,
    input  logic [3:0]  iwWstrb0,
    input  logic        iwReq1,
    input  logic        iwWe1,
    input  logic [31:0] iwAddr1,
    input  logic [31:0] iwWData1,
    input  logic [3:0]  iwWstrb1,
    output logic        owGnt0,
    output logic        owRValid0,
    output logic [31:0] owRData0,
    output logic        owGnt1,
    output logic        owRValid1,
    output logic [31:0] owRData1,
    output logic [31:0] owMemReadAddr,
    output logic [31:0] owMemWriteAddr,
    output logic [31:0] owMemWriteData,
    output logic [3:0]  owMemWstrb,
    input  logic [31:0] iwMemReadData
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    localparam logic [3:0] MAX = 4'(MAX_BURST);

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        tag_vld_q, tag_vld_d;
    logic        tag_id_q, tag_id_d;
    logic        own, owner, req_own, req_oth, stay, gnt, sel, we, wr, rd;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;

    always_comb begin
        own     = state_q != IDLE;
        owner   = state_q == OWN1;
        req_own = owner ? iwReq1 : iwReq0;
        req_oth = owner ? iwReq0 : iwReq1;
        stay    = req_own && (!req_oth || cnt_q < MAX);
        // From IDLE a tie goes to whoever was not served last.
        gnt     = !iwRst && (iwReq0 || iwReq1);
        sel     = own ? (stay ? owner : !owner) : ((iwReq0 && iwReq1) ? !last_q : iwReq1);
        we      = sel ? iwWe1 : iwWe0;
        addr    = sel ? iwAddr1 : iwAddr0;
        wdata   = sel ? iwWData1 : iwWData0;
        wstrb   = sel ? iwWstrb1 : iwWstrb0;
        wr      = gnt && we;
        rd      = gnt && !we;
        owGnt0  = gnt && !sel;
        owGnt1  = gnt && sel;
        owMemWriteAddr = wr ? addr : 32'd0;
        owMemWriteData = wr ? wdata : 32'd0;
        owMemWstrb     = wr ? wstrb : 4'd0;
        owMemReadAddr  = rd ? addr : 32'd0;
        state_d   = gnt ? (sel ? OWN1 : OWN0) : IDLE;
        last_d    = gnt ? sel : last_q;
        cnt_d     = !gnt ? 4'd0 : (own && sel == owner) ? ((cnt_q >= MAX) ? MAX : cnt_q + 4'd1) : 4'd1;
        tag_vld_d = rd;
        tag_id_d  = sel;
        owRValid0 = tag_vld_q && !tag_id_q && !iwRst;
        owRValid1 = tag_vld_q && tag_id_q && !iwRst;
        owRData0  = owRValid0 ? iwMemReadData : 32'd0;
        owRData1  = owRValid1 ? iwMemReadData : 32'd0;
    end

    always_ff @(posedge iwClk) begin
        if (iwRst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            cnt_q     <= 4'd0;
            tag_vld_q <= 1'b0;
            tag_id_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner sequences and random traffic
// checked against a rule-level arbiter model and a byte-accurate memory model.
module tb_mem_port_arbiter;
    localparam int MB = 4;

    logic        clk = 0;
    logic        rst = 1;
    logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [31:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
    logic [3:0]  wstrb0 = 0, wstrb1 = 0;
    logic        gnt0, gnt1, rv0, rv1;
    logic [31:0] rdata0, rdata1, mraddr, mwaddr, mwdata;
    logic [3:0]  mwstrb;
    logic [31:0] mem_rdata = 0;
    logic        u1g0, u1g1, u1rv0, u1rv1;
    logic [31:0] u1rd0, u1rd1, u1ra, u1wa, u1wd;
    logic [3:0]  u1ws;

    int n_chk = 0;
    int n_err = 0;

    mem_port_arbiter #(.MAX_BURST(MB)) dut (
        .iwClk(clk), .iwRst(rst),
        .iwReq0(req0), .iwWe0(we0), .iwAddr0(addr0), .iwWData0(wdata0), .iwWstrb0(wstrb0),
        .iwReq1(req1), .iwWe1(we1), .iwAddr1(addr1), .iwWData1(wdata1), .iwWstrb1(wstrb1),
        .owGnt0(gnt0), .owRValid0(rv0), .owRData0(rdata0),
        .owGnt1(gnt1), .owRValid1(rv1), .owRData1(rdata1),
        .owMemReadAddr(mraddr), .owMemWriteAddr(mwaddr), .owMemWriteData(mwdata),
        .owMemWstrb(mwstrb), .iwMemReadData(mem_rdata)
    );

    mem_port_arbiter #(.MAX_BURST(1)) dut1 (
        .iwClk(clk), .iwRst(rst),
        .iwReq0(req0), .iwWe0(we0), .iwAddr0(addr0), .iwWData0(wdata0), .iwWstrb0(wstrb0),
        .iwReq1(req1), .iwWe1(we1), .iwAddr1(addr1), .iwWData1(wdata1), .iwWstrb1(wstrb1),
        .owGnt0(u1g0), .owRValid0(u1rv0), .owRData0(u1rd0),
        .owGnt1(u1g1), .owRValid1(u1rv1), .owRData1(u1rd1),
        .owMemReadAddr(u1ra), .owMemWriteAddr(u1wa), .owMemWriteData(u1wd),
        .owMemWstrb(u1ws), .iwMemReadData(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory attached to the main instance: byte-strobed writes, 1-cycle read latency.
    logic [31:0] tmem [logic [31:0]];
    always @(posedge clk) begin
        logic [31:0] w;
        w = tmem.exists(mwaddr) ? tmem[mwaddr] : 32'd0;
        for (int b = 0; b < 4; b++) if (mwstrb[b]) w[b*8 +: 8] = mwdata[b*8 +: 8];
        if (mwstrb != 0) tmem[mwaddr] = w;
        mem_rdata <= tmem.exists(mraddr) ? tmem[mraddr] : 32'd0;
    end

    // Reference model state: who owns the port, who was served last, run length, pending read.
    int          m_owner = -1, m_last = 1, m_cnt = 0, m_pend = -1;
    logic [31:0] m_pend_data = 0;
    logic [31:0] mmem [logic [31:0]];

    function automatic logic [31:0] mread(input logic [31:0] a);
        return mmem.exists(a) ? mmem[a] : 32'd0;
    endfunction

    task automatic mwrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        w = mread(a);
        for (int b = 0; b < 4; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
        mmem[a] = w;
    endtask

    function automatic int pick(input logic r, input logic q0, input logic q1);
        logic rq [2];
        int x;
        rq[0] = q0;
        rq[1] = q1;
        if (r) return -1;
        if (m_owner < 0) begin
            if (q0 && q1) return 1 - m_last;
            return q0 ? 0 : (q1 ? 1 : -1);
        end
        x = m_owner;
        if (rq[x] && (!rq[1-x] || m_cnt < MB)) return x;
        return rq[1-x] ? 1 - x : -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic r, input logic q0, input logic q1, input logic w0, input logic w1,
                         input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] d0,
                         input logic [31:0] d1, input logic [3:0] s0, input logic [3:0] s1);
        int g;
        logic ew;
        logic [31:0] ea, ed;
        logic [3:0] es;
        @(negedge clk);
        rst = r; req0 = q0; req1 = q1; we0 = w0; we1 = w1;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1; wstrb0 = s0; wstrb1 = s1;
        #1;
        g  = pick(r, q0, q1);
        ew = (g == 1) ? w1 : w0;
        ea = (g == 1) ? a1 : a0;
        ed = (g == 1) ? d1 : d0;
        es = (g == 1) ? s1 : s0;
        chk("gnt", {gnt1, gnt0}, (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00);
        chk("waddr", mwaddr, (g >= 0 && ew) ? ea : 32'd0);
        chk("wdata", mwdata, (g >= 0 && ew) ? ed : 32'd0);
        chk("wstrb", mwstrb, (g >= 0 && ew) ? es : 4'd0);
        chk("raddr", mraddr, (g >= 0 && !ew) ? ea : 32'd0);
        chk("rvalid", {rv1, rv0}, r ? 2'b00 : (m_pend == 0) ? 2'b01 : (m_pend == 1) ? 2'b10 : 2'b00);
        chk("rdata0", rdata0, (!r && m_pend == 0) ? m_pend_data : 32'd0);
        chk("rdata1", rdata1, (!r && m_pend == 1) ? m_pend_data : 32'd0);
        chk("u1_excl", u1g0 & u1g1, 0);
        if (r) begin
            m_owner = -1; m_last = 1; m_cnt = 0; m_pend = -1;
        end else if (g >= 0) begin
            m_cnt = (g == m_owner) ? ((m_cnt + 1 > MB) ? MB : m_cnt + 1) : 1;
            m_owner = g;
            m_last = g;
            if (ew) mwrite(ea, ed, es);
            else m_pend_data = mread(ea);
            m_pend = ew ? -1 : g;
        end else begin
            m_owner = -1; m_cnt = 0; m_pend = -1;
        end
    endtask

    typedef struct {
        logic r, q0, q1, w0, w1;
        logic [1:0] g;
    } vec_t;

    initial begin
        vec_t tbl [16];
        tbl[0] = '{1, 1, 1, 0, 0, 2'b00};
        for (int i = 1; i <= 4; i++) tbl[i] = '{0, 1, 1, 0, 0, 2'b01};
        for (int i = 5; i <= 8; i++) tbl[i] = '{0, 1, 1, 0, 0, 2'b10};
        tbl[9]  = '{0, 1, 1, 0, 0, 2'b01};
        tbl[10] = '{0, 1, 0, 0, 0, 2'b01};
        tbl[11] = '{0, 0, 0, 0, 0, 2'b00};
        tbl[12] = '{0, 0, 1, 1, 1, 2'b10};
        tbl[13] = '{0, 1, 1, 0, 0, 2'b10};
        tbl[14] = '{0, 0, 0, 0, 0, 2'b00};
        tbl[15] = '{1, 1, 1, 0, 0, 2'b00};
        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].r, tbl[i].q0, tbl[i].q1, tbl[i].w0, tbl[i].w1,
                  32'h20, 32'h24, 32'h1111_0000 + i, 32'h2222_0000 + i, 4'hF, 4'h3);
            chk($sformatf("tbl_gnt[%0d]", i), {gnt1, gnt0}, tbl[i].g);
        end

        // Write then read back the same word from requester 0.
        cycle(0, 1, 0, 1, 0, 32'h10, 0, 32'hDEADBEEF, 0, 4'hF, 0);
        chk("wr_gnt0", gnt0, 1);
        chk("wr_wstrb", mwstrb, 4'hF);
        cycle(0, 1, 0, 0, 0, 32'h10, 0, 0, 0, 0, 0);
        chk("rd_gnt0", gnt0, 1);
        chk("rd_addr", mraddr, 32'h10);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rb_valid0", rv0, 1);
        chk("rb_data0", rdata0, 32'hDEADBEEF);

        // Owner 1 drops while 0 raises: immediate handover, fresh burst of MB.
        cycle(0, 0, 1, 0, 0, 0, 32'h14, 0, 0, 0, 0);
        chk("ho_g1", gnt1, 1);
        cycle(0, 1, 0, 0, 0, 32'h18, 0, 0, 0, 0, 0);
        chk("ho_g0", gnt0, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 1, 0, 0, 32'h18, 32'h14, 0, 0, 0, 0);
            chk("ho_burst", {gnt1, gnt0}, 2'b01);
        end
        cycle(0, 1, 1, 0, 0, 32'h18, 32'h14, 0, 0, 0, 0);
        chk("ho_switch", {gnt1, gnt0}, 2'b10);

        // Reset right after a granted read of requester 1.
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0, 32'h10, 0, 0, 0, 0);
        chk("rst_g1", gnt1, 1);
        cycle(1, 1, 1, 1, 1, 32'h4, 32'h8, 32'h5, 32'h6, 4'hF, 4'hF);
        chk("rst_rv1", rv1, 0);
        chk("rst_outs", {gnt0, gnt1, rv0, rdata0, rdata1, mwstrb}, 0);
        chk("rst_addrs", {mraddr, mwaddr}, 0);
        cycle(0, 1, 1, 0, 0, 32'h4, 32'h8, 0, 0, 0, 0);
        chk("rst_first", {gnt1, gnt0}, 2'b01);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_no_rv1", rv1, 0);

        // MAX_BURST = 1 instance strictly alternates under constant contention.
        cycle(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1, 1, 0, 0, 32'h30, 32'h34, 0, 0, 0, 0);
            chk("alt_u1", {u1g1, u1g0}, (i % 2 == 0) ? 2'b01 : 2'b10);
        end

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7),
                  1'($urandom), 1'($urandom),
                  {27'd0, 3'($urandom), 2'b00}, {27'd0, 3'($urandom), 2'b00},
                  $urandom, $urandom, 4'($urandom), 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
